// File: rtl/dlsc_pcie_s6_rxfifo.sv
// Store-and-forward receive FIFO for the Spartan-6 PCIe TRN interface.
// Words of a TLP become visible downstream only once the whole TLP has
// arrived cleanly; poisoned, truncated and oversized TLPs are discarded.
module dlsc_pcie_s6_rxfifo #(
    parameter int DATA = 32,
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DATA-1:0] trn_rd,
    input  logic            trn_rsof_n,
    input  logic            trn_reof_n,
    input  logic            trn_rsrc_rdy_n,
    input  logic            trn_rerrfwd_n,
    output logic            trn_rdst_rdy_n,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic            rd_last,
    output logic [DATA-1:0] rd_data,
    output logic            err_drop
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DROP
    } state_t;

    localparam logic [ADDR:0] DEPTH = {1'b1, {ADDR{1'b0}}};

    logic [DATA:0]   mem [2**ADDR];

    logic [ADDR:0]   wr_ptr;
    logic [ADDR:0]   commit_ptr;
    logic [ADDR:0]   rd_ptr;
    logic [ADDR:0]   wr_ptr_nx;
    logic [ADDR:0]   commit_ptr_nx;
    logic [ADDR-1:0] waddr;
    state_t          state;
    state_t          state_nx;
    logic            err;
    logic            err_nx;
    logic            drop_nx;
    logic            we;
    logic            full;
    logic            stall;
    logic            beat;
    logic            pop;

    assign full  = (wr_ptr - rd_ptr) == DEPTH;
    // A TLP that fills the whole buffer with nothing committed ahead of it
    // can never complete, so it must be abandoned.
    assign stall = (state == ST_PKT) && full && (commit_ptr == rd_ptr);

    // Stall is a subset of full; in DROP nothing is stored, so always ready.
    assign trn_rdst_rdy_n = (state != ST_DROP) && (full || stall);

    assign beat     = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign rd_valid = (rd_ptr != commit_ptr);
    assign pop      = rd_ready && rd_valid;

    assign {rd_last, rd_data} = mem[rd_ptr[ADDR-1:0]];

    // Next-state, write-enable and pointer updates for the receive side.
    always_comb begin
        state_nx      = state;
        wr_ptr_nx     = wr_ptr;
        commit_ptr_nx = commit_ptr;
        err_nx        = err;
        drop_nx       = 1'b0;
        we            = 1'b0;
        waddr         = wr_ptr[ADDR-1:0];
        case (state)
            ST_IDLE, ST_PKT: begin
                if (stall) begin
                    wr_ptr_nx = commit_ptr;
                    err_nx    = 1'b0;
                    state_nx  = ST_DROP;
                end else if (beat) begin
                    if (!trn_rsof_n) begin
                        // A sof while in PKT abandons the partial TLP; writing at
                        // commit_ptr covers both that rewind and the IDLE case,
                        // where wr_ptr already equals commit_ptr.
                        drop_nx   = (state == ST_PKT);
                        we        = 1'b1;
                        waddr     = commit_ptr[ADDR-1:0];
                        wr_ptr_nx = commit_ptr + 1'b1;
                        err_nx    = !trn_rerrfwd_n;
                        state_nx  = ST_PKT;
                    end else if (state == ST_PKT) begin
                        we        = 1'b1;
                        wr_ptr_nx = wr_ptr + 1'b1;
                        err_nx    = err || !trn_rerrfwd_n;
                    end else begin
                        drop_nx   = 1'b1;
                    end
                    if (we && !trn_reof_n) begin
                        if (err_nx) begin
                            wr_ptr_nx = commit_ptr;
                            drop_nx   = 1'b1;
                        end else begin
                            commit_ptr_nx = wr_ptr_nx;
                        end
                        err_nx   = 1'b0;
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (beat && !trn_reof_n) begin
                    drop_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Data storage; contents are don't-care until committed, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {!trn_reof_n, trn_rd};
        end
    end

    // State, pointers, error latch and drop pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            err        <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            commit_ptr <= commit_ptr_nx;
            err        <= err_nx;
            err_drop   <= drop_nx;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_rxfifo.sv
// Self-checking bench for dlsc_pcie_s6_rxfifo: a queue-based packet model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_dlsc_pcie_s6_rxfifo;

    localparam int DATA  = 32;
    localparam int ADDR  = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DATA-1:0] trn_rd = '0;
    logic            trn_rsof_n = 1'b1;
    logic            trn_reof_n = 1'b1;
    logic            trn_rsrc_rdy_n = 1'b1;
    logic            trn_rerrfwd_n = 1'b1;
    logic            trn_rdst_rdy_n;
    logic            rd_ready = 1'b0;
    logic            rd_valid;
    logic            rd_last;
    logic [DATA-1:0] rd_data;
    logic            err_drop;

    always #5 clk = ~clk;

    dlsc_pcie_s6_rxfifo #(
        .DATA (DATA),
        .ADDR (ADDR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trn_rd         (trn_rd),
        .trn_rsof_n     (trn_rsof_n),
        .trn_reof_n     (trn_reof_n),
        .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
        .trn_rerrfwd_n  (trn_rerrfwd_n),
        .trn_rdst_rdy_n (trn_rdst_rdy_n),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_last        (rd_last),
        .rd_data        (rd_data),
        .err_drop       (err_drop)
    );

    // ---------------- packet-level model ----------------
    typedef enum int {M_IDLE, M_PKT, M_DROP} mode_t;
    typedef struct packed {
        logic            last;
        logic [DATA-1:0] data;
    } word_t;

    word_t           outq[$];      // committed, not yet popped
    logic [DATA-1:0] pend[$];      // current partial TLP
    mode_t           mode = M_IDLE;
    logic            m_err = 1'b0;
    logic            exp_drop = 1'b0;

    int vectors = 0;
    int fails   = 0;

    function automatic logic exp_rdy_n();
        return (mode != M_DROP) && (outq.size() + pend.size() == DEPTH);
    endfunction

    // Close the current TLP: publish it whole, or throw it away if poisoned.
    function automatic logic finish_tlp();
        logic dropped = 1'b0;
        if (m_err) begin
            dropped = 1'b1;
        end else begin
            for (int i = 0; i < pend.size(); i++) begin
                outq.push_back({(i == pend.size() - 1), pend[i]});
            end
        end
        pend.delete();
        m_err = 1'b0;
        mode  = M_IDLE;
        return dropped;
    endfunction

    function automatic logic start_tlp(input logic [DATA-1:0] d, input logic eof, input logic errf);
        logic dropped = 1'b0;
        pend.delete();
        pend.push_back(d);
        m_err = errf;
        mode  = M_PKT;
        if (eof) dropped = finish_tlp();
        return dropped;
    endfunction

    task automatic model_step();
        logic full;
        logic acc;
        logic was_empty;
        logic sof;
        logic eof;
        logic errf;
        logic dn;
        full      = (outq.size() + pend.size() == DEPTH);
        acc       = !trn_rsrc_rdy_n && !exp_rdy_n();
        was_empty = (outq.size() == 0);
        sof       = !trn_rsof_n;
        eof       = !trn_reof_n;
        errf      = !trn_rerrfwd_n;
        dn        = 1'b0;
        if (rd_ready && !was_empty) void'(outq.pop_front());
        if (mode == M_PKT && full && was_empty) begin
            pend.delete();
            m_err = 1'b0;
            mode  = M_DROP;
        end else if (acc) begin
            case (mode)
                M_IDLE: begin
                    if (sof) dn = start_tlp(trn_rd, eof, errf);
                    else     dn = 1'b1;
                end
                M_PKT: begin
                    if (sof) begin
                        void'(start_tlp(trn_rd, eof, errf));
                        dn = 1'b1;
                    end else begin
                        pend.push_back(trn_rd);
                        m_err = m_err | errf;
                        if (eof) dn = finish_tlp();
                    end
                end
                default: begin
                    if (eof) begin
                        dn   = 1'b1;
                        mode = M_IDLE;
                    end
                end
            endcase
        end
        exp_drop = dn;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                outq.delete();
                pend.delete();
                mode     = M_IDLE;
                m_err    = 1'b0;
                exp_drop = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("rdst_rdy_n", trn_rdst_rdy_n, exp_rdy_n());
            check("rd_valid", rd_valid, outq.size() != 0);
            check("err_drop", err_drop, exp_drop);
            if (outq.size() != 0) begin
                check("rd_data", rd_data, outq[0].data);
                check("rd_last", rd_last, outq[0].last);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send(input logic [DATA-1:0] d, input logic sof, input logic eof, input logic errf);
        logic acc = 1'b0;
        int unsigned n = 0;
        trn_rd         = d;
        trn_rsof_n     = !sof;
        trn_reof_n     = !eof;
        trn_rerrfwd_n  = !errf;
        trn_rsrc_rdy_n = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = !trn_rdst_rdy_n;
            cyc();
            n++;
        end
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rerrfwd_n  = 1'b1;
        trn_rd         = '0;
        check("beat_accepted", acc, 1'b1);
    endtask

    task automatic expect_word(input string name, input logic [DATA-1:0] d, input logic last);
        @(negedge clk);
        check({name, "_valid"}, rd_valid, 1'b1);
        check({name, "_data"}, rd_data, d);
        check({name, "_last"}, rd_last, last);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_rdy_n", trn_rdst_rdy_n, 1'b0);
        check("rst_drop", err_drop, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // three-word TLP, streamed out back to back after eof
        rd_ready = 1'b1;
        send(32'hD000_0000, 1'b1, 1'b0, 1'b0);
        send(32'hD000_0001, 1'b0, 1'b0, 1'b0);
        send(32'hD000_0002, 1'b0, 1'b1, 1'b0);
        expect_word("t3w0", 32'hD000_0000, 1'b0);
        expect_word("t3w1", 32'hD000_0001, 1'b0);
        expect_word("t3w2", 32'hD000_0002, 1'b1);
        @(negedge clk);
        check("t3_empty", rd_valid, 1'b0);
        cyc();

        // single-beat TLP
        send(32'h1111_0001, 1'b1, 1'b1, 1'b0);
        expect_word("t1", 32'h1111_0001, 1'b1);
        cyc();

        // poisoned TLP is dropped with one pulse
        send(32'h2000_0000, 1'b1, 1'b0, 1'b0);
        send(32'h2000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h2000_0002, 1'b0, 1'b0, 1'b0);
        send(32'h2000_0003, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("poison_drop", err_drop, 1'b1);
        check("poison_novalid", rd_valid, 1'b0);
        @(negedge clk);
        check("poison_pulse_end", err_drop, 1'b0);
        cyc();

        // fill the buffer with four 4-word TLPs while downstream is stalled
        rd_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < 4; w++) begin
                send(32'h0000_0400 + t * 16 + w, w == 0, w == 3, 1'b0);
            end
        end
        @(negedge clk);
        check("fill_rdy_n", trn_rdst_rdy_n, 1'b1);
        check("fill_head", rd_data, 32'h0000_0400);
        check("model_fill", outq.size(), 16);
        cyc();
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        @(negedge clk);
        check("refill_rdy_n", trn_rdst_rdy_n, 1'b0);
        check("refill_head", rd_data, 32'h0000_0401);
        cyc();
        rd_ready = 1'b1;
        begin
            int unsigned n = 0;
            while (rd_valid && n < 40) begin
                cyc();
                n++;
            end
            check("drain_done", rd_valid, 1'b0);
        end

        // oversized TLP stalls, drops, then the buffer recovers
        for (int i = 0; i < 20; i++) begin
            send(32'h0000_0600 + i, i == 0, i == 19, 1'b0);
        end
        @(negedge clk);
        check("big_drop", err_drop, 1'b1);
        check("big_novalid", rd_valid, 1'b0);
        cyc();
        send(32'h0000_0700, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0701, 1'b0, 1'b1, 1'b0);
        expect_word("after_big0", 32'h0000_0700, 1'b0);
        expect_word("after_big1", 32'h0000_0701, 1'b1);
        cyc();

        // sof in the middle of a TLP restarts it
        send(32'h0000_0800, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0801, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0802, 1'b0, 1'b1, 1'b0);
        expect_word("restart0", 32'h0000_0801, 1'b0);
        expect_word("restart1", 32'h0000_0802, 1'b1);
        cyc();

        // stray beat outside a TLP
        send(32'h0000_0900, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stray_drop", err_drop, 1'b1);
        check("stray_novalid", rd_valid, 1'b0);
        cyc();

        // reset in the middle of a TLP
        send(32'h0000_0A00, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0A01, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", rd_valid, 1'b0);
        check("midrst_rdy_n", trn_rdst_rdy_n, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        send(32'h0000_0B00, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0B01, 1'b0, 1'b1, 1'b0);
        expect_word("postrst0", 32'h0000_0B00, 1'b0);
        expect_word("postrst1", 32'h0000_0B01, 1'b1);
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/dlsc_pcie_s6_rxfifo.md
DLSC_PCIE_S6_RXFIFO -- requirements
Module: dlsc_pcie_s6_rxfifo

Interface
REQ-001 Parameter DATA, default 32: width of TLP data words.
REQ-002 Parameter ADDR, default 4: buffer depth is 2**ADDR words.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port trn_rd, input, DATA: receive data word from the PCIe core.
REQ-007 Port trn_rsof_n, input, 1: active-low start of TLP.
REQ-008 Port trn_reof_n, input, 1: active-low end of TLP.
REQ-009 Port trn_rsrc_rdy_n, input, 1: active-low beat valid.
REQ-010 Port trn_rerrfwd_n, input, 1: active-low poisoned-TLP flag, valid on any beat.
REQ-011 Port trn_rdst_rdy_n, output, 1: active-low ready to the core.
REQ-012 Port rd_ready, input, 1: downstream ready.
REQ-013 Port rd_valid, output, 1: output word valid.
REQ-014 Port rd_last, output, 1: output word is the last word of its TLP.
REQ-015 Port rd_data, output, DATA: output word.
REQ-016 Port err_drop, output, 1: one-cycle pulse per discarded TLP or stray beat.

Function
REQ-017 Beat accepted = !trn_rsrc_rdy_n && !trn_rdst_rdy_n; pop = rd_ready && rd_valid.
REQ-018 Storage: 2**ADDR entries of {eof, data}; pointers wr_ptr, commit_ptr, rd_ptr, each ADDR+1 bits, wrapping modulo 2**(ADDR+1).
REQ-019 Full = (wr_ptr - rd_ptr) == 2**ADDR.
REQ-020 Store-and-forward: rd_valid = (rd_ptr != commit_ptr); only committed words are visible.
REQ-021 rd_data/rd_last SHALL be driven combinationally from entry rd_ptr, stable while rd_valid && !rd_ready.
REQ-022 Pop SHALL advance rd_ptr by 1; push and pop in the same cycle are both honoured.
REQ-023 trn_rdst_rdy_n = 1 when full or in the cycle a stall is detected (REQ-030), else 0; in DROP it is 0.
REQ-024 FSM states: IDLE, PKT, DROP; reset state IDLE.
REQ-025 IDLE, accepted beat with sof: write word, advance wr_ptr, latch err = !trn_rerrfwd_n; go PKT, or process as eof per REQ-027 if eof is on the same beat.
REQ-026 IDLE, accepted beat without sof: discard, pulse err_drop, stay IDLE.
REQ-027 PKT, accepted beat: write word and advance wr_ptr; OR errfwd into err. On eof: if err (including this beat) set wr_ptr to commit_ptr and pulse err_drop, else set commit_ptr to wr_ptr+1; go IDLE.
REQ-028 PKT, accepted beat with sof: rewind wr_ptr to commit_ptr, pulse err_drop, then write this beat as a new TLP start per REQ-025.
REQ-029 Commit and pop in the same cycle SHALL both take effect; rd_valid rises the cycle after commit (zero extra latency).
REQ-030 Stall: in PKT with full and commit_ptr == rd_ptr (TLP longer than buffer), rewind wr_ptr to commit_ptr and go DROP next cycle.
REQ-031 DROP: accept and discard every beat; on eof pulse err_drop and go IDLE.
REQ-032 Pointer differences SHALL use ADDR+1-bit modular arithmetic; no separate counters.

Reset
REQ-033 While rst_n = 0: all pointers 0, state IDLE, err 0, rd_valid 0, err_drop 0, trn_rdst_rdy_n 0.
REQ-034 Reset mid-TLP SHALL discard all buffered and partial data; the next accepted beat is treated per IDLE rules.
REQ-035 Memory contents need not be reset.

Verification
REQ-036 ADDR=4, 3-word TLP D0..D2, rd_ready=1 -> rd_valid low until cycle after eof beat; then D0,D1,D2 on consecutive cycles, rd_last only with D2.
REQ-037 1-word TLP with sof and eof on one beat -> single output word with rd_last=1, rd_valid one cycle after the beat.
REQ-038 4-word TLP with trn_rerrfwd_n=0 on word 1 -> no output, err_drop one pulse after the eof beat, wr_ptr == commit_ptr.
REQ-039 rd_ready=0, stream 4-word TLPs -> four TLPs (16 words) buffered, trn_rdst_rdy_n=1; one pop re-enables acceptance next cycle.
REQ-040 20-word TLP into empty buffer -> stall after 16 words, DROP, all 20 beats accepted, one err_drop, no output; following 2-word TLP delivered intact.
REQ-041 Beat without sof in IDLE -> err_drop pulse, nothing stored; assert rst_n=0 mid-TLP -> rd_valid 0 and next TLP delivered correctly.
